ram_access_arbiter: RTL

- Shares the single-port 16-bit program/data RAM between two requesters: the CPU and the video character fetcher, which reads characters for the VGA controller.
- Sits between the CPU bus, the video fetch unit and the RAM instance inside the kit top level.
- Sequences each access through a small FSM and waits a fixed read latency before returning data.
- Holds the RAM write strobe low except during the one committed write cycle.

---
 rtl/ram_access_arbiter_pkg.sv | 47 ++++
 rtl/ram_access_arbiter_arb_pick.sv | 67 ++++++
 rtl/ram_access_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_access_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_access_arbiter_pkg
//
// Purpose : Shared definitions for the RAM access arbiter that lets the CPU
//           and the video character fetcher take turns on one single-port
//           16-bit program/data RAM.
//
// Contents:
//   DEF_ADDR_W / DEF_DATA_W : default address and data widths (16/16)
//   state_t                 : access sequencer states IDLE/ISSUE/WAIT/DONE
//   owner_t                 : which requester owns the access in flight
//   RW_READ / RW_WRITE      : encoding of the cpu_rw / ram_rw direction bit
//   CNT_W, lat_preset()     : read-latency counter width and its preset value
// ---------------------------------------------------------------------------
package ram_access_arbiter_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Sequencer states. IDLE is the only state in which requests are looked at.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // OWN_CPU is the cleared value, so a reset leaves the owner pointing at
    // the CPU with nothing in flight.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } owner_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Read latency is limited to 1..3, so a 2-bit down-counter is enough.
    localparam int CNT_W = 2;

    // WAIT is entered with RD_LAT-1 and leaves when the counter reads zero,
    // which makes WAIT last exactly RD_LAT cycles.
    function automatic logic [CNT_W-1:0] lat_preset(input int rd_lat);
        return CNT_W'(rd_lat - 1);
    endfunction

endpackage

// File: rtl/ram_access_arbiter_arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
//
// Purpose : Chooses which requester wins when the access sequencer is idle.
//           Default build: fixed priority, video wins every contest.
//           With ARB_ROUND_ROBIN_EN defined: contested grants alternate via a
//           1-bit pointer that starts at video and flips to the loser after
//           each contested grant; uncontested grants leave it alone.
//
// Ports   :
//   clock      in   system clock
//   reset_n    in   asynchronous active-low reset (clears pointer to video)
//   i_cpu_req  in   CPU request level
//   i_vid_req  in   video request level
//   i_take     in   sequencer is committing a grant this cycle
//   o_winner   out  requester to be served (meaningful when a request exists)
//
// Configuration macro: ARB_ROUND_ROBIN_EN
// ---------------------------------------------------------------------------
module arb_pick
    import ram_access_arbiter_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   i_cpu_req,
    input  logic   i_vid_req,
    input  logic   i_take,
    output owner_t o_winner
);

`ifdef ARB_ROUND_ROBIN_EN

    owner_t r_ptr;
    logic   w_contest;

    assign w_contest = i_cpu_req & i_vid_req;

    // Only a contested grant moves the pointer; it then favours the loser.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= OWN_VID;
        end else if (i_take && w_contest) begin
            r_ptr <= (r_ptr == OWN_VID) ? OWN_CPU : OWN_VID;
        end
    end

    always_comb begin
        o_winner = OWN_CPU;
        if (w_contest) begin
            o_winner = r_ptr;
        end else if (i_vid_req) begin
            o_winner = OWN_VID;
        end
    end

`else

    // Fixed priority needs no state; the clock, reset and take strobe are
    // only used by the alternating build.
    logic w_unused;
    assign w_unused = ^{clock, reset_n, i_take, i_cpu_req};

    assign o_winner = i_vid_req ? OWN_VID : OWN_CPU;

`endif

endmodule

// File: rtl/ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// ram_access_arbiter
//
// Purpose : Shares one single-port RAM between the CPU bus and the video
//           character fetcher. Every access runs IDLE -> ISSUE -> (WAIT x
//           RD_LAT, reads only) -> DONE -> IDLE, so exactly one access is in
//           flight and there is at least one IDLE cycle between accesses.
//           ram_rw is high only in the ISSUE cycle of a CPU write.
//
// Parameters:
//   ADDR_W  address width (default 16)
//   DATA_W  data width (default 16)
//   RD_LAT  RAM read latency in cycles, 1..3
//
// Ports   :
//   clock, reset_n                 clock, asynchronous active-low reset
//   cpu_req/cpu_rw/cpu_addr/cpu_wdata  CPU request (held until cpu_ack)
//   cpu_gnt, cpu_ack, cpu_rdata        CPU grant/ack pulses, read data
//   vid_req/vid_addr                   video read request (held until vid_ack)
//   vid_gnt, vid_ack, vid_rdata        video grant/ack pulses, read data
//   ram_addr/ram_wdata/ram_rw/ram_rdata  RAM side
//
// Configuration macro: ARB_ROUND_ROBIN_EN (handled inside arb_pick)
// ---------------------------------------------------------------------------
module ram_access_arbiter
    import ram_access_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_rw,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t             r_state;
    state_t             w_state_next;
    owner_t             r_owner;
    logic               r_rw;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_cpu_rdata;
    logic [DATA_W-1:0]  r_vid_rdata;

    logic               w_any_req;
    logic               w_take;
    logic               w_cnt_zero;
    owner_t             w_winner;

    assign w_any_req  = cpu_req | vid_req;
    assign w_take     = (r_state == IDLE) && w_any_req;
    assign w_cnt_zero = (r_cnt == '0);

    // -----------------------------------------------------------------------
    // Winner selection
    // -----------------------------------------------------------------------
    arb_pick u_arb_pick (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_cpu_req (cpu_req),
        .i_vid_req (vid_req),
        .i_take    (w_take),
        .o_winner  (w_winner)
    );

    // -----------------------------------------------------------------------
    // Sequencer state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and strobes. All strobes decode from registered state, so
    // a reset forces them low immediately and none of them depend
    // combinationally on the request inputs.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        cpu_gnt      = 1'b0;
        vid_gnt      = 1'b0;
        cpu_ack      = 1'b0;
        vid_ack      = 1'b0;
        ram_rw       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_next = ISSUE;
                end
            end

            ISSUE: begin
                cpu_gnt = (r_owner == OWN_CPU);
                vid_gnt = (r_owner == OWN_VID);
                // Video owners always latch RW_READ; the owner term keeps the
                // write strobe physically tied to the CPU path regardless.
                ram_rw  = (r_owner == OWN_CPU) && (r_rw == RW_WRITE);
                w_state_next = (r_rw == RW_WRITE) ? DONE : WAIT;
            end

            WAIT: begin
                if (w_cnt_zero) begin
                    w_state_next = DONE;
                end
            end

            DONE: begin
                cpu_ack = (r_owner == OWN_CPU);
                vid_ack = (r_owner == OWN_VID);
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Access latch, latency counter and read-data capture.
    // The request fields are copied once, at the IDLE sample, so the access
    // finishes unchanged even if the requester drops or changes its inputs
    // afterwards.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_owner     <= OWN_CPU;
            r_rw        <= RW_READ;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_owner <= w_winner;
                        if (w_winner == OWN_VID) begin
                            r_addr  <= vid_addr;
                            r_wdata <= '0;
                            r_rw    <= RW_READ;
                        end else begin
                            r_addr  <= cpu_addr;
                            r_wdata <= cpu_wdata;
                            r_rw    <= cpu_rw;
                        end
                    end
                end

                ISSUE: begin
                    r_cnt <= lat_preset(RD_LAT);
                end

                WAIT: begin
                    if (w_cnt_zero) begin
                        // Only the owner's register moves; the other keeps
                        // the last word it was handed.
                        if (r_owner == OWN_VID) begin
                            r_vid_rdata <= ram_rdata;
                        end else begin
                            r_cpu_rdata <= ram_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign cpu_rdata = r_cpu_rdata;
    assign vid_rdata = r_vid_rdata;

    // -----------------------------------------------------------------------
    // Protocol properties
    // -----------------------------------------------------------------------
    ap_single_gnt : assert property (@(posedge clock) disable iff (!reset_n)
        !(cpu_gnt && vid_gnt));
    ap_single_ack : assert property (@(posedge clock) disable iff (!reset_n)
        !(cpu_ack && vid_ack));
    ap_rw_in_issue : assert property (@(posedge clock) disable iff (!reset_n)
        ram_rw |-> cpu_gnt);

endmodule
